// File: rtl/lii_pkg.sv
// rtl/lii_pkg.sv - shared id width and sizing helpers for the LII stream adapter
package lii_pkg;

    localparam int LII_ID_W = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int beats(input int w, input int pw);
        return (w + pw - 1) / pw;
    endfunction

endpackage

// File: rtl/lii_sync_fifo.sv
// rtl/lii_sync_fifo.sv - single-clock FIFO with registered occupancy count
module lii_sync_fifo
    import lii_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic [clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/lii_stream_adapter.sv
// rtl/lii_stream_adapter.sv - LII phy <-> HLS kernel width adapter with output FIFO and ce
// Optional destination filter and drop counter: LII_DST_FILTER_EN
module lii_stream_adapter
    import lii_pkg::*;
#(
    parameter int                  PW      = 256,
    parameter int                  IW      = 96,
    parameter int                  OW      = 192,
    parameter int                  ODEPTH  = 4,
    parameter logic [LII_ID_W-1:0] MY_ID   = 8'h00,
    parameter logic [LII_ID_W-1:0] OUT_DST = 8'h00
) (
    input  logic                aclk,
    input  logic                arstn,
    input  logic [PW-1:0]       lii_in_tdata,
    input  logic                lii_in_tvalid,
    output logic                lii_in_tready,
    input  logic [LII_ID_W-1:0] lii_in_src,
    input  logic [LII_ID_W-1:0] lii_in_dst,
    output logic [PW-1:0]       lii_out_tdata,
    output logic                lii_out_tvalid,
    input  logic                lii_out_tready,
    output logic [LII_ID_W-1:0] lii_out_src,
    output logic [LII_ID_W-1:0] lii_out_dst,
    output logic [IW-1:0]       k_in_tdata,
    output logic                k_in_tvalid,
    input  logic                k_in_tready,
    input  logic [OW-1:0]       k_out_tdata,
    input  logic                k_out_tvalid,
    output logic                k_out_tready,
    output logic                ce
`ifdef LII_DST_FILTER_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);
    localparam int IBEATS = beats(IW, PW);
    localparam int OBEATS = beats(OW, PW);
    localparam int IBW    = (IBEATS > 1) ? clog2(IBEATS) : 1;
    localparam int OBW    = (OBEATS > 1) ? clog2(OBEATS) : 1;
    localparam int CW     = clog2(ODEPTH) + 1;
    localparam logic [IBW-1:0] ILAST    = IBW'(IBEATS - 1);
    localparam logic [OBW-1:0] OLAST    = OBW'(OBEATS - 1);
    localparam logic [CW-1:0]  CE_LIMIT = CW'(ODEPTH - 2);

    logic                 rst_done_q, rst_done_d;
    logic [IBW-1:0]       ibeat_q, ibeat_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [IW-1:0]        hold_q, hold_d;
    logic [OBW-1:0]       obeat_q, obeat_d;
    logic                 in_hs, in_keep, beat_hs, last_hs, k_hs;
    logic                 out_hs, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [OW-1:0]        fifo_head;
    logic [OBEATS*PW-1:0] head_pad;
    logic [CW-1:0]        fifo_count;
    logic                 unused_inputs;

    assign unused_inputs = ^{lii_in_tdata, lii_in_src, lii_in_dst};
    assign lii_out_src   = MY_ID;
    assign lii_out_dst   = OUT_DST;

    assign lii_in_tready = rst_done_q & (~hold_valid_q | k_in_tready);
    assign in_hs         = lii_in_tvalid & lii_in_tready;
`ifdef LII_DST_FILTER_EN
    assign in_keep       = (lii_in_dst == MY_ID);
`else
    assign in_keep       = 1'b1;
`endif
    assign beat_hs       = in_hs & in_keep;
    assign last_hs       = beat_hs & (ibeat_q == ILAST);
    assign k_hs          = hold_valid_q & k_in_tready;
    assign k_in_tvalid   = hold_valid_q;
    assign k_in_tdata    = hold_q;

    // A new beat 0 may land while the kernel drains the old word; the
    // kernel samples hold_q before this cycle's write takes effect.
    always_comb begin
        rst_done_d   = 1'b1;
        ibeat_d      = ibeat_q;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        if (beat_hs) begin
            ibeat_d = last_hs ? '0 : ibeat_q + 1'b1;
            for (int b = 0; b < IW; b++) begin
                if (b / PW == int'(ibeat_q)) hold_d[b] = lii_in_tdata[b % PW];
            end
        end
        if (last_hs) hold_valid_d = 1'b1;
        else if (k_hs) hold_valid_d = 1'b0;
    end

    assign k_out_tready   = rst_done_q & ~fifo_full;
    assign fifo_push      = k_out_tvalid & k_out_tready;
    assign lii_out_tvalid = ~fifo_empty;
    assign out_hs         = lii_out_tvalid & lii_out_tready;
    assign fifo_pop       = out_hs & (obeat_q == OLAST);
    // Headroom of two keeps room for a result the kernel already has in flight
    assign ce             = rst_done_q & (fifo_count <= CE_LIMIT);

    always_comb begin
        head_pad         = '0;
        head_pad[OW-1:0] = fifo_head;
        obeat_d          = obeat_q;
        if (out_hs) obeat_d = (obeat_q == OLAST) ? '0 : obeat_q + 1'b1;
    end

    assign lii_out_tdata = head_pad[int'(obeat_q) * PW +: PW];

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            rst_done_q   <= 1'b0;
            ibeat_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            obeat_q      <= '0;
        end else begin
            rst_done_q   <= rst_done_d;
            ibeat_q      <= ibeat_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            obeat_q      <= obeat_d;
        end
    end

`ifdef LII_DST_FILTER_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_hs && !in_keep && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

    lii_sync_fifo #(
        .WIDTH (OW),
        .DEPTH (ODEPTH)
    ) u_out_fifo (
        .clk       (aclk),
        .rst_n     (arstn),
        .push      (fifo_push),
        .push_data (k_out_tdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_lii_stream_adapter.sv
// tb/tb_lii_stream_adapter.sv - self-checking bench for lii_stream_adapter (LII_DST_FILTER_EN optional)
`timescale 1ns/1ps
module tb_lii_stream_adapter;
    localparam int         PW      = 64;
    localparam int         IW      = 96;
    localparam int         OW      = 192;
    localparam int         ODEPTH  = 4;
    localparam logic [7:0] MY_ID   = 8'h05;
    localparam logic [7:0] OUT_DST = 8'h33;

    logic          aclk = 1'b0;
    logic          arstn = 1'b0;
    logic [63:0]   in_tdata;
    logic          in_tvalid;
    logic          in_tready;
    logic [7:0]    in_src, in_dst;
    logic [63:0]   out_tdata;
    logic          out_tvalid;
    logic          out_tready;
    logic [7:0]    out_src, out_dst;
    logic [95:0]   k_in_tdata;
    logic          k_in_tvalid;
    logic          k_in_tready;
    logic [191:0]  k_out_tdata;
    logic          k_out_tvalid;
    logic          k_out_tready;
    logic          ce;
`ifdef LII_DST_FILTER_EN
    logic [15:0]   drop_cnt;
`endif

    lii_stream_adapter #(
        .PW      (PW),
        .IW      (IW),
        .OW      (OW),
        .ODEPTH  (ODEPTH),
        .MY_ID   (MY_ID),
        .OUT_DST (OUT_DST)
    ) dut (
        .aclk           (aclk),
        .arstn          (arstn),
        .lii_in_tdata   (in_tdata),
        .lii_in_tvalid  (in_tvalid),
        .lii_in_tready  (in_tready),
        .lii_in_src     (in_src),
        .lii_in_dst     (in_dst),
        .lii_out_tdata  (out_tdata),
        .lii_out_tvalid (out_tvalid),
        .lii_out_tready (out_tready),
        .lii_out_src    (out_src),
        .lii_out_dst    (out_dst),
        .k_in_tdata     (k_in_tdata),
        .k_in_tvalid    (k_in_tvalid),
        .k_in_tready    (k_in_tready),
        .k_out_tdata    (k_out_tdata),
        .k_out_tvalid   (k_out_tvalid),
        .k_out_tready   (k_out_tready),
        .ce             (ce)
`ifdef LII_DST_FILTER_EN
        ,
        .drop_cnt       (drop_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0]  b0;
        logic [63:0]  b1;
        logic [95:0]  k_exp;
        logic [191:0] r;
        logic [63:0]  e0;
        logic [63:0]  e1;
        logic [63:0]  e2;
    } vec_t;

    vec_t vecs [4];

    int n_cmp = 0;
    int n_bad = 0;

    logic [95:0]  kq [$];
    logic [63:0]  ib [$];
    logic [191:0] oq [$];
    int           ids [$];
    int           obeat;
    int           drops;
    bit           exp_in_rdy, push_m, keep_m;
    logic [191:0] hw;
    logic [127:0] w2;
    logic [63:0]  eb;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge aclk);
        #1;
    endtask

    task automatic mid();
        @(negedge aclk);
    endtask

    function automatic logic [191:0] mkw(input int i);
        logic [63:0] a, b, c;
        a = 64'(i * 16);
        b = 64'(i * 16 + 1);
        c = 64'(i * 16 + 2);
        return {c, b, a};
    endfunction

    task automatic drain_ids(input string name);
        for (int n = 0; n < ids.size(); n++) begin
            mid();
            check({name, "_v"}, out_tvalid, 1'b1);
            check(name, out_tdata, 64'(ids[n]));
            next();
        end
        mid();
        check({name, "_empty"}, out_tvalid, 1'b0);
        next();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_tdata = '0; in_tvalid = 0; in_src = '0; in_dst = MY_ID;
        out_tready = 0; k_in_tready = 0; k_out_tdata = '0; k_out_tvalid = 0;

        vecs[0] = '{64'h1111111111111111, 64'h2222222222222222, 96'h22222222_1111111111111111,
                    192'hcccccccccccccccc_bbbbbbbbbbbbbbbb_aaaaaaaaaaaaaaaa,
                    64'haaaaaaaaaaaaaaaa, 64'hbbbbbbbbbbbbbbbb, 64'hcccccccccccccccc};
        vecs[1] = '{64'h0123456789abcdef, 64'hfedcba9876543210, 96'h76543210_0123456789abcdef,
                    192'h0000000000000003_0000000000000002_0000000000000001,
                    64'h1, 64'h2, 64'h3};
        vecs[2] = '{64'h0, 64'hffffffffffffffff, 96'hffffffff_0000000000000000,
                    192'h8000000000000000_0000000000000000_0000000000000001,
                    64'h1, 64'h0, 64'h8000000000000000};
        vecs[3] = '{64'hffffffffffffffff, 64'h0, 96'h00000000_ffffffffffffffff,
                    192'hdeadbeefdeadbeef_0123456789abcdef_fedcba9876543210,
                    64'hfedcba9876543210, 64'h0123456789abcdef, 64'hdeadbeefdeadbeef};

        // reset held for three cycles, then readys/ce one cycle after release
        repeat (3) begin
            mid();
            check("rst_outs", {in_tready, k_out_tready, ce, k_in_tvalid, out_tvalid}, 5'b0);
            next();
        end
        arstn = 1;
        mid();
        check("rel_readys_early", {in_tready, k_out_tready, ce}, 3'b000);
        next();
        mid();
        check("rel_readys", {in_tready, k_out_tready, ce}, 3'b111);
        check("out_ids", {out_src, out_dst}, {MY_ID, OUT_DST});
        next();

        for (int i = 0; i < 4; i++) begin
            in_tvalid = 1; in_tdata = vecs[i].b0; k_in_tready = 0;
            mid();
            check("des_rdy", in_tready, 1'b1);
            next();
            in_tdata = vecs[i].b1;
            mid();
            check("des_v_early", k_in_tvalid, 1'b0);
            next();
            in_tvalid = 0;
            mid();
            check("des_valid", k_in_tvalid, 1'b1);
            check("des_word", k_in_tdata, vecs[i].k_exp);
            check("des_block", in_tready, 1'b0);
            next();
            k_in_tready = 1;
            mid();
            check("des_rdy_drain", in_tready, 1'b1);
            next();
            k_in_tready = 0;
            mid();
            check("des_cleared", k_in_tvalid, 1'b0);
            next();

            out_tready = 1; k_out_tvalid = 1; k_out_tdata = vecs[i].r;
            mid();
            check("ser_kready", k_out_tready, 1'b1);
            check("ser_v_early", out_tvalid, 1'b0);
            next();
            k_out_tvalid = 0;
            mid(); check("ser_b0", {out_tvalid, out_tdata}, {1'b1, vecs[i].e0}); next();
            mid(); check("ser_b1", {out_tvalid, out_tdata}, {1'b1, vecs[i].e1}); next();
            mid(); check("ser_b2", {out_tvalid, out_tdata}, {1'b1, vecs[i].e2}); next();
            mid();
            check("ser_empty", {out_tvalid, ce}, 2'b01);
            next();
            out_tready = 0;
        end

        // backpressure: fill to ODEPTH, then pop while full
        for (int i = 0; i < 4; i++) begin
            k_out_tvalid = 1; k_out_tdata = mkw(i + 1);
            mid();
            check("bp_kready", k_out_tready, 1'b1);
            check("bp_ce", ce, (i <= 2));
            next();
        end
        k_out_tvalid = 0;
        mid();
        check("bp_full", {k_out_tready, ce, out_tvalid}, 3'b001);
        check("bp_head", out_tdata, 64'(16));
        next();
        mid();
        check("bp_stable", out_tdata, 64'(16));
        next();
        out_tready = 1; k_out_tvalid = 1; k_out_tdata = mkw(5);
        for (int k = 0; k < 3; k++) begin
            mid();
            check("full_pop_refuse", k_out_tready, 1'b0);
            check("bp_beat", out_tdata, 64'(16 + k));
            next();
        end
        mid();
        check("bp_room", {k_out_tready, ce}, 2'b10);
        check("bp_next_head", out_tdata, 64'(32));
        next();
        k_out_tvalid = 0;
        ids.delete();
        for (int k = 1; k < 3; k++) ids.push_back(32 + k);
        for (int w = 3; w < 6; w++) for (int k = 0; k < 3; k++) ids.push_back(w * 16 + k);
        drain_ids("bp_drain");

        // push and pop in the same cycle at count 2
        out_tready = 0;
        k_out_tvalid = 1; k_out_tdata = mkw(6); next();
        k_out_tdata = mkw(7); next();
        k_out_tvalid = 0; out_tready = 1;
        mid();
        check("pp_ce_before", ce, 1'b1);
        next();
        next();
        k_out_tvalid = 1; k_out_tdata = mkw(8);
        mid();
        check("pp_kready", k_out_tready, 1'b1);
        check("pp_last_beat", out_tdata, 64'(98));
        next();
        k_out_tvalid = 0; out_tready = 0;
        mid();
        check("pp_ce_after", {ce, k_out_tready}, 2'b11);
        check("pp_head", out_tdata, 64'(112));
        next();
        out_tready = 1;
        ids.delete();
        for (int w = 7; w < 9; w++) for (int k = 0; k < 3; k++) ids.push_back(w * 16 + k);
        drain_ids("pp_drain");
        out_tready = 0;

        // kernel drain overlapping a new beat 0
        in_tvalid = 1; k_in_tready = 0;
        in_tdata = 64'hAAAA000000000001; next();
        in_tdata = 64'hAAAA000000000002; next();
        in_tdata = 64'hBBBB000000000003; k_in_tready = 1;
        mid();
        check("ovl_rdy", in_tready, 1'b1);
        check("ovl_old", k_in_tdata, 96'h00000002_AAAA000000000001);
        next();
        k_in_tready = 0; in_tdata = 64'hBBBB000000000004;
        mid();
        check("ovl_cleared", k_in_tvalid, 1'b0);
        next();
        in_tvalid = 0;
        mid();
        check("ovl_new", {k_in_tvalid, k_in_tdata}, {1'b1, 96'h00000004_BBBB000000000003});
        next();
        k_in_tready = 1; next(); k_in_tready = 0;

`ifdef LII_DST_FILTER_EN
        in_tvalid = 1; in_dst = 8'h07;
        for (int k = 0; k < 3; k++) begin
            in_tdata = 64'(100 + k);
            mid();
            check("flt_rdy", in_tready, 1'b1);
            next();
        end
        in_dst = MY_ID; in_tvalid = 0;
        mid();
        check("flt_drop_cnt", drop_cnt, 16'd3);
        check("flt_no_word", k_in_tvalid, 1'b0);
        next();
        in_tvalid = 1; in_tdata = 64'h55; next();
        in_tdata = 64'h66; next();
        in_tvalid = 0;
        mid();
        check("flt_word", {k_in_tvalid, k_in_tdata}, {1'b1, 96'h00000066_0000000000000055});
        next();
        k_in_tready = 1; next(); k_in_tready = 0;
`endif

        // reset in the middle of traffic
        k_out_tvalid = 1; k_out_tdata = mkw(9); next();
        k_out_tvalid = 0;
        in_tvalid = 1; in_tdata = 64'h77; next();
        in_tvalid = 0;
        arstn = 0;
        mid();
        check("mrst_outs", {in_tready, k_out_tready, ce, k_in_tvalid, out_tvalid}, 5'b0);
        next();
        arstn = 1;
        mid();
        next();
        out_tready = 1; k_in_tready = 1;
        repeat (4) begin
            mid();
            check("mrst_quiet", {out_tvalid, k_in_tvalid}, 2'b00);
            next();
        end
        k_in_tready = 0; in_tvalid = 1;
        in_tdata = 64'h10; next();
        in_tdata = 64'h20; next();
        in_tvalid = 0;
        mid();
        check("mrst_fresh_word", {k_in_tvalid, k_in_tdata}, {1'b1, 96'h00000020_0000000000000010});
        next();
        k_in_tready = 1; next();

        // randomized traffic against a queue-level model
        kq.delete(); ib.delete(); oq.delete(); obeat = 0; drops = 0;
        for (int c = 0; c < 3000; c++) begin
            in_tvalid    = ($urandom_range(0, 1) == 1);
            in_tdata     = {$urandom, $urandom};
            in_src       = 8'($urandom);
            in_dst       = ($urandom_range(0, 3) == 0) ? 8'h07 : MY_ID;
            k_in_tready  = ($urandom_range(0, 2) != 0);
            k_out_tvalid = ($urandom_range(0, 1) == 1);
            k_out_tdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            out_tready   = ($urandom_range(0, 9) < (((c / 400) % 2 == 0) ? 3 : 8));
            mid();
            exp_in_rdy = (kq.size() == 0) || k_in_tready;
            check("rnd_k_in_tvalid", k_in_tvalid, kq.size() != 0);
            if (kq.size() != 0) check("rnd_k_in_tdata", k_in_tdata, kq[0]);
            check("rnd_in_tready", in_tready, exp_in_rdy);
            check("rnd_k_out_tready", k_out_tready, oq.size() < ODEPTH);
            check("rnd_ce", ce, oq.size() <= ODEPTH - 2);
            check("rnd_out_tvalid", out_tvalid, oq.size() != 0);
            if (oq.size() != 0) begin
                hw = oq[0];
                eb = hw[obeat * 64 +: 64];
                check("rnd_out_tdata", out_tdata, eb);
            end
`ifdef LII_DST_FILTER_EN
            check("rnd_drop_cnt", drop_cnt, 16'(drops));
`endif
            if (kq.size() != 0 && k_in_tready) void'(kq.pop_front());
            keep_m = 1'b1;
`ifdef LII_DST_FILTER_EN
            keep_m = (in_dst == MY_ID);
`endif
            if (in_tvalid && exp_in_rdy) begin
                if (!keep_m) drops++;
                else begin
                    ib.push_back(in_tdata);
                    if (ib.size() == 2) begin
                        w2 = {ib[1], ib[0]};
                        kq.push_back(w2[95:0]);
                        ib.delete();
                    end
                end
            end
            push_m = k_out_tvalid && (oq.size() < ODEPTH);
            if (oq.size() != 0 && out_tready) begin
                obeat++;
                if (obeat == 3) begin
                    void'(oq.pop_front());
                    obeat = 0;
                end
            end
            if (push_m) oq.push_back(k_out_tdata);
            next();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
